// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the system reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      PWR_UP     = 3'd0,
      ASSERT     = 3'd1,
      WAIT_CLK   = 3'd2,
      REL_PERIPH = 3'd3,
      RUN        = 3'd4
   } state_t;

   localparam int CAUSE_POR  = 0;
   localparam int CAUSE_NDM  = 1;
   localparam int CAUSE_WDOG = 2;
   localparam int CAUSE_SW   = 3;

   localparam logic [3:0] CAUSE_RESET = 4'(1 << CAUSE_POR);

   // Map the three request sources onto their cause-register bit positions.
   function automatic logic [3:0] cause_bits(input logic ndm, input logic wdog, input logic sw);
      logic [3:0] b;
      b             = '0;
      b[CAUSE_NDM]  = ndm;
      b[CAUSE_WDOG] = wdog;
      b[CAUSE_SW]   = sw;
      return b;
   endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchroniser for a slow asynchronous level, cleared to 0 by reset.
// Latency: 2 clk_i cycles.
// Backpressure: none.
module rst_sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/rst_seq_ctrl.sv
// System reset sequencer: merges POR/PLL-lock/NDM/WDOG/SW requests; RST_CAUSE_EN keeps the cause register.
// Latency: outputs registered from next-state; request in RUN drops all resets on the next edge.
// Backpressure: none; waits on clk_enb_i with a CLK_WAIT_MAX timeout.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int HOLD_CYCLES  = 16,
   parameter int PERIPH_DLY   = 8,
   parameter int CLK_WAIT_MAX = 2048,
   parameter int CNT_W        = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pll_lock_i,
   input  logic       ndm_req_i,
   input  logic       wdog_bite_i,
   input  logic       sw_rst_req_i,
   input  logic       clk_enb_i,
   output logic       sys_rst_no,
   output logic       periph_rst_no,
   output logic       cpu_rst_no,
   output logic       rst_busy_o,
   output logic       clk_timeout_o,
   output logic [3:0] rst_cause_o
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(CLK_WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] ENB_MASKED  = CNT_W'(2);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lock_s;
   logic [3:0]       req_bits;
   logic             req_any;
   logic             lock_lost;
   logic             timeout_hit;
   logic             sys_d, periph_d, cpu_d, busy_d;

   rst_sync_2ff u_lock_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .din    (pll_lock_i),
      .dout   (lock_s)
   );

   assign req_bits  = cause_bits(ndm_req_i, wdog_bite_i, sw_rst_req_i);
   assign req_any   = |req_bits;
   assign lock_lost = !lock_s && (state_q != PWR_UP);

   // Next state and counter; lock loss overrides any same-cycle request.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      if (lock_lost) begin
         state_d = PWR_UP;
      end else begin
         case (state_q)
            PWR_UP:     if (lock_s) state_d = ASSERT;
            ASSERT:     if (!req_any && cnt_q == HOLD_LAST) state_d = WAIT_CLK;
            WAIT_CLK: begin
               if (req_any) begin
                  state_d = ASSERT;
               end else if (cnt_q >= ENB_MASKED && clk_enb_i) begin
                  state_d = REL_PERIPH;
               end else if (cnt_q == WAIT_LAST) begin
                  state_d     = REL_PERIPH;
                  timeout_hit = 1'b1;
               end
            end
            REL_PERIPH: begin
               if (req_any)                   state_d = ASSERT;
               else if (cnt_q == PERIPH_LAST) state_d = RUN;
            end
            RUN:        if (req_any) state_d = ASSERT;
            default:    state_d = PWR_UP;
         endcase
      end

      if (state_d != state_q || req_any)
         cnt_d = '0;
      else if (state_q == ASSERT || state_q == WAIT_CLK || state_q == REL_PERIPH)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
   end

   // Output decode from the next state so outputs move with the state register.
   always_comb begin
      sys_d    = (state_d != PWR_UP) && (state_d != ASSERT);
      periph_d = (state_d == REL_PERIPH) || (state_d == RUN);
      cpu_d    = (state_d == RUN);
      busy_d   = (state_d != RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= PWR_UP;
         cnt_q         <= '0;
         sys_rst_no    <= 1'b0;
         periph_rst_no <= 1'b0;
         cpu_rst_no    <= 1'b0;
         rst_busy_o    <= 1'b1;
         clk_timeout_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sys_rst_no    <= sys_d;
         periph_rst_no <= periph_d;
         cpu_rst_no    <= cpu_d;
         rst_busy_o    <= busy_d;
         if (timeout_hit)
            clk_timeout_o <= 1'b1;
      end
   end

`ifdef RST_CAUSE_EN
   logic [3:0] cause_q;

   // A request out of RUN starts a fresh record; requests mid-sequence accumulate.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cause_q <= CAUSE_RESET;
      end else if (!lock_lost && req_any) begin
         if (state_q == RUN)
            cause_q <= req_bits;
         else if (state_q != PWR_UP)
            cause_q <= cause_q | req_bits;
      end
   end

   assign rst_cause_o = cause_q;
`else
   assign rst_cause_o = 4'b0000;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with a phase/timer reference model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_seq_ctrl;

   localparam int HOLD = 16;
   localparam int PDLY = 8;
   localparam int WMAX = 2048;

   // Phases ordered so that "resets released" reads as a simple threshold.
   localparam int P_OFF  = 0;
   localparam int P_HOLD = 1;
   localparam int P_CLKW = 2;
   localparam int P_PERI = 3;
   localparam int P_RUN  = 4;

   localparam int O_SYS  = 0;
   localparam int O_PERI = 1;
   localparam int O_CPU  = 2;

`ifdef RST_CAUSE_EN
   localparam logic [3:0] CAUSE_MASK = 4'hF;
`else
   localparam logic [3:0] CAUSE_MASK = 4'h0;
`endif

   logic       clk_i        = 1'b0;
   logic       rst_ni       = 1'b0;
   logic       pll_lock_i   = 1'b0;
   logic       ndm_req_i    = 1'b0;
   logic       wdog_bite_i  = 1'b0;
   logic       sw_rst_req_i = 1'b0;
   logic       clk_enb_i    = 1'b0;
   logic       sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o, clk_timeout_o;
   logic [3:0] rst_cause_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   rst_seq_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pll_lock_i    (pll_lock_i),
      .ndm_req_i     (ndm_req_i),
      .wdog_bite_i   (wdog_bite_i),
      .sw_rst_req_i  (sw_rst_req_i),
      .clk_enb_i     (clk_enb_i),
      .sys_rst_no    (sys_rst_no),
      .periph_rst_no (periph_rst_no),
      .cpu_rst_no    (cpu_rst_no),
      .rst_busy_o    (rst_busy_o),
      .clk_timeout_o (clk_timeout_o),
      .rst_cause_o   (rst_cause_o)
   );

   // Reference model: a phase, a countdown for fixed dwells, an age for the clock wait.
   int         m_ph, m_left, m_age, n_ph, n_left, n_age;
   logic [1:0] m_sync;
   logic       m_to, n_to, lock_ok, req;
   logic [3:0] m_cause, n_cause, rq_bits;

   always_comb begin
      lock_ok = m_sync[1];
      rq_bits = {sw_rst_req_i, wdog_bite_i, ndm_req_i, 1'b0};
      req     = |rq_bits;
      n_ph    = m_ph;
      n_left  = m_left;
      n_age   = m_age + 1;
      n_to    = m_to;
      n_cause = m_cause;
      if (m_ph != P_OFF && !lock_ok) begin
         n_ph = P_OFF;
      end else if (m_ph == P_OFF) begin
         if (lock_ok) begin
            n_ph   = P_HOLD;
            n_left = HOLD;
         end
      end else if (req) begin
         n_ph    = P_HOLD;
         n_left  = HOLD;
         n_cause = (m_ph == P_RUN) ? rq_bits : (m_cause | rq_bits);
      end else if (m_ph == P_HOLD) begin
         if (m_left == 1) begin
            n_ph  = P_CLKW;
            n_age = 0;
         end else begin
            n_left = m_left - 1;
         end
      end else if (m_ph == P_CLKW) begin
         if ((m_age >= 2 && clk_enb_i) || m_age == WMAX - 1) begin
            n_ph   = P_PERI;
            n_left = PDLY;
            if (!(m_age >= 2 && clk_enb_i)) n_to = 1'b1;
         end
      end else if (m_ph == P_PERI) begin
         if (m_left == 1) n_ph = P_RUN;
         else             n_left = m_left - 1;
      end
   end

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_ph    <= P_OFF;
         m_left  <= 0;
         m_age   <= 0;
         m_sync  <= 2'b00;
         m_to    <= 1'b0;
         m_cause <= 4'b0001;
      end else begin
         m_ph    <= n_ph;
         m_left  <= n_left;
         m_age   <= n_age;
         m_sync  <= {m_sync[0], pll_lock_i};
         m_to    <= n_to;
         m_cause <= n_cause;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] cexp(input logic [3:0] v);
      return v & CAUSE_MASK;
   endfunction

   function automatic logic out_bit(input int which);
      case (which)
         O_SYS:   return sys_rst_no;
         O_PERI:  return periph_rst_no;
         O_CPU:   return cpu_rst_no;
         default: return 1'b0;
      endcase
   endfunction

   // Counts edges until the output reaches val; an expired budget is a failed check.
   task automatic wait_out(input int which, input logic val, input int budget,
                           input string name, output int n);
      n = 0;
      while (n < budget) begin
         @(posedge clk_i);
         #1;
         n++;
         if (out_bit(which) == val) return;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s: no level %0d within %0d cycles", name, val, budget);
      n = -1;
   endtask

   // Per-cycle compare of every output against the model.
   initial begin
      @(posedge clk_i);
      forever begin
         #1;
         check("cycle_outputs",
               int'({sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o, clk_timeout_o, rst_cause_o}),
               int'({m_ph >= P_CLKW, m_ph >= P_PERI, m_ph == P_RUN, m_ph != P_RUN, m_to, cexp(m_cause)}));
         @(posedge clk_i);
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      // POR path
      pll_lock_i = 1'b1;
      repeat (5) @(negedge clk_i);
      check("reset_outs", int'({sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o, clk_timeout_o}), 5'b00010);
      check("reset_cause", int'(rst_cause_o), int'(cexp(4'b0001)));
      rst_ni = 1'b1;
      wait_out(O_SYS, 1'b1, 100, "por_sys_rise", n);
      check("por_sys_low_edges", n, 2 + 1 + HOLD);
      repeat (1001) @(posedge clk_i);
      @(negedge clk_i) clk_enb_i = 1'b1;
      wait_out(O_PERI, 1'b1, 4, "por_periph_rise", n);
      check("por_periph_after_enb", n, 1);
      wait_out(O_CPU, 1'b1, 20, "por_cpu_rise", n);
      check("por_cpu_after_periph", n, PDLY);
      check("por_cause", int'(rst_cause_o), int'(cexp(4'b0001)));
      check("por_no_timeout", int'(clk_timeout_o), 0);

      // Watchdog in RUN; clock enable already high, so only the 2-cycle mask applies
      @(negedge clk_i) wdog_bite_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("wdog_resets_low", int'({sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o}), 4'b0001);
      check("wdog_cause", int'(rst_cause_o), int'(cexp(4'b0100)));
      @(negedge clk_i) wdog_bite_i = 1'b0;
      wait_out(O_SYS, 1'b1, 40, "wdog_sys_rise", n);
      check("wdog_hold_edges", n, HOLD);
      wait_out(O_PERI, 1'b1, 10, "wdog_periph_rise", n);
      check("wdog_enb_mask_edges", n, 3);
      wait_out(O_CPU, 1'b1, 20, "wdog_cpu_rise", n);
      check("wdog_cpu_after_periph", n, PDLY);

      // NDM held 40 cycles with a simultaneous SW pulse
      @(negedge clk_i);
      ndm_req_i    = 1'b1;
      sw_rst_req_i = 1'b1;
      @(negedge clk_i) sw_rst_req_i = 1'b0;
      repeat (39) @(negedge clk_i);
      ndm_req_i = 1'b0;
      wait_out(O_SYS, 1'b1, 40, "ndm_sys_rise", n);
      check("ndm_hold_after_drop", n, HOLD);
      check("ndm_cause", int'(rst_cause_o), int'(cexp(4'b1010)));
      wait_out(O_CPU, 1'b1, 40, "ndm_cpu_rise", n);

      // Clock enable stuck low
      @(negedge clk_i);
      clk_enb_i    = 1'b0;
      sw_rst_req_i = 1'b1;
      @(negedge clk_i) sw_rst_req_i = 1'b0;
      wait_out(O_SYS, 1'b1, 40, "to_sys_rise", n);
      check("to_hold_edges", n, HOLD);
      check("to_cause", int'(rst_cause_o), int'(cexp(4'b1000)));
      wait_out(O_PERI, 1'b1, 3000, "to_periph_rise", n);
      check("to_wait_edges", n, WMAX);
      check("to_flag_set", int'(clk_timeout_o), 1);
      wait_out(O_CPU, 1'b1, 20, "to_cpu_rise", n);
      check("to_cpu_after_periph", n, PDLY);
      @(negedge clk_i);
      clk_enb_i    = 1'b1;
      sw_rst_req_i = 1'b1;
      @(negedge clk_i) sw_rst_req_i = 1'b0;
      wait_out(O_CPU, 1'b1, 100, "to_sw_cpu_rise", n);
      check("to_flag_persists", int'(clk_timeout_o), 1);

      // Lock loss in REL_PERIPH coinciding with a watchdog bite
      @(negedge clk_i) ndm_req_i = 1'b1;
      @(negedge clk_i) ndm_req_i = 1'b0;
      wait_out(O_PERI, 1'b1, 60, "ll_periph_rise", n);
      @(negedge clk_i) pll_lock_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i) wdog_bite_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("ll_resets_low", int'({sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o}), 4'b0001);
      check("ll_cause_kept", int'(rst_cause_o), int'(cexp(4'b0010)));
      @(negedge clk_i) wdog_bite_i = 1'b0;
      repeat (4) @(negedge clk_i);
      pll_lock_i = 1'b1;
      wait_out(O_CPU, 1'b1, 200, "ll_restart_cpu", n);
      check("ll_restart_cause", int'(rst_cause_o), int'(cexp(4'b0010)));
      check("ll_flag_persists", int'(clk_timeout_o), 1);

      // Asynchronous reset mid-RUN
      @(negedge clk_i) rst_ni = 1'b0;
      #1;
      check("async_reset_outs", int'({sys_rst_no, periph_rst_no, cpu_rst_no, rst_busy_o, clk_timeout_o}), 5'b00010);
      check("async_reset_cause", int'(rst_cause_o), int'(cexp(4'b0001)));
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
